// File: rtl/logic_tt_sequencer.sv
// logic_tt_sequencer: walks the external 2-input gate datapath through the
// truth table of every gate enabled in gate_mask. Each operand pair is held
// for DWELL cycles, the datapath result is checked against the ideal gate,
// and the outcome of the run is shown on the RGB LEDs.
module logic_tt_sequencer #(
  parameter int DWELL = 20000000,
  parameter int GAP   = 10000000,
  parameter int CNT_W = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       hold,
  input  logic [5:0] gate_mask,
  input  logic       result,
  output logic [2:0] gate_sel,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       redled,
  output logic       greenled,
  output logic       blueled
);

  typedef enum logic [1:0] {ST_IDLE, ST_DWELL, ST_GAP, ST_DONE} state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       combo;
  logic [5:0]       mask_q;

  logic             sample_bad;
  logic             err_next;
  logic [3:0]       first_pick;
  logic [3:0]       later_pick;
  logic [3:0]       gap_pick;

  // Ideal truth table for opcode op (same encoding as the gate_mask bits).
  function automatic logic ideal_out(input logic [2:0] op, input logic a, input logic b);
    case (op)
      3'd0:    ideal_out = a & b;
      3'd1:    ideal_out = a | b;
      3'd2:    ideal_out = a ^ b;
      3'd3:    ideal_out = ~(a & b);
      3'd4:    ideal_out = ~(a | b);
      3'd5:    ideal_out = ~(a ^ b);
      default: ideal_out = 1'b0;
    endcase
  endfunction

  // Lowest set bit of m at or above position from; bit 3 flags that one exists.
  function automatic logic [3:0] next_gate(input logic [5:0] m, input logic [2:0] from);
    next_gate = 4'b0000;
    for (int i = 5; i >= 0; i--) begin
      if (m[i] && (3'(i) >= from)) next_gate = {1'b1, 3'(i)};
    end
  endfunction

  // Check of the current operand pair and the gate-order lookups.
  always_comb begin
    sample_bad = (result != ideal_out(gate_sel, combo[1], combo[0]));
    err_next   = err | sample_bad;
    first_pick = next_gate(gate_mask, 3'd0);
    later_pick = next_gate(mask_q, gate_sel + 3'd1);
    gap_pick   = next_gate(gate_mask, gate_sel + 3'd1);
  end

  assign gate_a  = combo[1];
  assign gate_b  = combo[0];
  assign blueled = busy;

  // Sequencer FSM: schedules gates and combos, samples results, drives LEDs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      combo    <= 2'd0;
      mask_q   <= 6'd0;
      gate_sel <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      redled   <= 1'b0;
      greenled <= 1'b0;
    end else if (abort) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      combo    <= 2'd0;
      mask_q   <= 6'd0;
      gate_sel <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      redled   <= 1'b0;
      greenled <= 1'b0;
    end else if (!hold) begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            err      <= 1'b0;
            cnt      <= '0;
            combo    <= 2'd0;
            redled   <= 1'b0;
            greenled <= 1'b0;
            mask_q   <= gate_mask;
            if (first_pick[3]) begin
              gate_sel <= first_pick[2:0];
              state    <= ST_DWELL;
              busy     <= 1'b1;
              done     <= 1'b0;
            end else begin
              gate_sel <= 3'd0;
              state    <= ST_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              greenled <= 1'b1;
            end
          end
        end
        ST_DWELL: begin
          if (cnt == DWELL_LAST) begin
            cnt <= '0;
            err <= err_next;
            if (combo != 2'd3) begin
              combo  <= combo + 2'd1;
              redled <= result;
            end else if (later_pick[3]) begin
              state  <= ST_GAP;
              redled <= 1'b0;
            end else begin
              state    <= ST_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              redled   <= err_next;
              greenled <= ~err_next;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt    <= '0;
            mask_q <= gate_mask;
            if (gap_pick[3]) begin
              gate_sel <= gap_pick[2:0];
              combo    <= 2'd0;
              state    <= ST_DWELL;
            end else begin
              state    <= ST_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              redled   <= err;
              greenled <= ~err;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_tt_sequencer.sv
// tb_logic_tt_sequencer: scoreboard bench. Each run is expanded by a schedule
// model into a per-cycle list of expected outputs; a monitor compares the DUT
// against that list on the falling edge, tagged by cycle number.
module tb_logic_tt_sequencer;

  localparam int DWELL = 4;
  localparam int GAP   = 2;
  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       hold;
  logic [5:0] gate_mask;
  logic       result;
  logic [2:0] gate_sel;
  logic       gate_a;
  logic       gate_b;
  logic       busy;
  logic       done;
  logic       err;
  logic       redled;
  logic       greenled;
  logic       blueled;

  typedef struct {
    int unsigned cyc;
    logic [10:0] v;
    bit          care;
  } ent_t;

  ent_t        exp_q[$];
  logic [10:0] trace[$];
  bit          trace_care[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  string       cur_case = "reset";

  bit          fault_en = 1'b0;
  logic [2:0]  fault_gate = 3'd0;
  logic [1:0]  fault_combo = 2'd0;

  logic_tt_sequencer #(.DWELL(DWELL), .GAP(GAP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
    .gate_mask(gate_mask), .result(result), .gate_sel(gate_sel),
    .gate_a(gate_a), .gate_b(gate_b), .busy(busy), .done(done), .err(err),
    .redled(redled), .greenled(greenled), .blueled(blueled)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit ideal_f(input int op, input bit a, input bit b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return !(a & b);
      4: return !(a | b);
      5: return !(a ^ b);
      default: return 1'b0;
    endcase
  endfunction

  // Datapath model with an optional stuck-wrong operand pair.
  assign result = ideal_f(int'(gate_sel), gate_a, gate_b) ^
                  (fault_en && gate_sel == fault_gate && {gate_a, gate_b} == fault_combo);

  function automatic logic [10:0] mk(input int sel, input bit a, input bit b, input bit bz,
                                     input bit dn, input bit e, input bit rd, input bit gr);
    return {3'(sel), a, b, bz, dn, e, rd, gr, bz};
  endfunction

  task automatic checkOutput(input string name, input int unsigned tag,
                             input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s (%s) cyc=%0d actual=%0h required=%0h", name, cur_case, tag, act, req);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit ab, input bit h, input logic [5:0] m);
    start     = s;
    abort     = ab;
    hold      = h;
    gate_mask = m;
  endtask

  task automatic push_exp(input logic [10:0] v, input bit care);
    ent_t e;
    e.cyc  = cyc + 1;
    e.v    = v;
    e.care = care;
    exp_q.push_back(e);
  endtask

  // Schedule model: gates ascending, 4 combos x DWELL cycles, GAP dark cycles between.
  task automatic build_trace(input logic [5:0] m);
    bit e, r, samp, first, a, b;
    trace.delete();
    trace_care.delete();
    e = 1'b0;
    first = 1'b1;
    for (int g = 0; g < 6; g++) begin
      if (m[g]) begin
        if (!first) begin
          for (int k = 0; k < GAP; k++) begin
            trace.push_back(mk(0, 0, 0, 1, 0, e, 0, 0));
            trace_care.push_back(1'b0);
          end
        end
        r = 1'b0;
        for (int c = 0; c < 4; c++) begin
          a = (c >= 2);
          b = ((c % 2) == 1);
          for (int k = 0; k < DWELL; k++) begin
            trace.push_back(mk(g, a, b, 1, 0, e, r, 0));
            trace_care.push_back(1'b1);
          end
          samp = ideal_f(g, a, b) ^ (fault_en && int'(fault_gate) == g && int'(fault_combo) == c);
          if (samp != ideal_f(g, a, b)) e = 1'b1;
          r = samp;
        end
        first = 1'b0;
      end
    end
    trace.push_back(mk(0, 0, 0, 0, 1, e, e, !e));
    trace_care.push_back(1'b0);
  endtask

  // Runs one start..DONE (or abort) sequence; called at posedge+2.
  task automatic run_case(input string name, input logic [5:0] m, input bit fen, input int fg,
                          input int fc, input int hold_pct, input int hold_from,
                          input int hold_len, input int abort_at);
    int  idx, j, last;
    bit  hb, finished;
    cur_case    = name;
    fault_en    = fen;
    fault_gate  = 3'(fg);
    fault_combo = 2'(fc);
    build_trace(m);
    last = trace.size() - 1;
    applyStimulus(1'b1, 1'b0, 1'b0, m);
    idx = 0;
    push_exp(trace[0], trace_care[0]);
    @(posedge clk); #2;
    j = 1;
    finished = 1'b0;
    while (!finished) begin
      if (abort_at == j) begin
        applyStimulus(1'b0, 1'b1, 1'b0, m);
        push_exp(11'd0, 1'b1);
        @(posedge clk); #2;
        applyStimulus(1'b0, 1'b0, 1'b0, m);
        push_exp(11'd0, 1'b1);
        @(posedge clk); #2;
        finished = 1'b1;
      end else if (idx == last) begin
        applyStimulus(1'b0, 1'b0, 1'b0, m);
        push_exp(trace[last], trace_care[last]);
        @(posedge clk); #2;
        finished = 1'b1;
      end else if (j > 3000) begin
        checks++;
        failures++;
        $display("[TB] FAIL run_budget (%s) cycles=%0d required_below=3000", name, j);
        finished = 1'b1;
      end else begin
        hb = (j >= hold_from && j < hold_from + hold_len) ||
             (int'($urandom_range(0, 99)) < hold_pct);
        applyStimulus(1'b0, 1'b0, hb, m);
        if (!hb) idx++;
        push_exp(trace[idx], trace_care[idx]);
        @(posedge clk); #2;
        j++;
      end
    end
  endtask

  // Monitor: compares the DUT against every expected entry due this cycle.
  initial begin : monitor
    ent_t        ent;
    logic [10:0] act, req;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        ent = exp_q.pop_front();
        if (ent.cyc != cyc) begin
          checkOutput("entry_cycle", ent.cyc, 32'(cyc), 32'(ent.cyc));
        end else begin
          act = {gate_sel, gate_a, gate_b, busy, done, err, redled, greenled, blueled};
          req = ent.v;
          if (!ent.care) begin
            act[10:6] = 5'd0;
            req[10:6] = 5'd0;
          end
          checkOutput("outputs", ent.cyc, 32'(act), 32'(req));
        end
      end
    end
  end

  initial begin : stimulus
    logic [5:0] m;
    int         fg;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0);
    #1;
    checkOutput("reset_state", 0,
                32'({gate_sel, gate_a, gate_b, busy, done, err, redled, greenled, blueled}), 32'd0);
    #12 rst_n = 1'b1;
    @(posedge clk); #2;

    run_case("xor_ideal",   6'b000100, 1'b0, 0, 0, 0, 0, 0, -1);
    run_case("and_nand",    6'b001001, 1'b0, 0, 0, 0, 0, 0, -1);
    run_case("xor_fault01", 6'b000100, 1'b1, 2, 1, 0, 0, 0, -1);
    run_case("abort_all",   6'b111111, 1'b0, 0, 0, 0, 0, 0, 6);
    run_case("rerun_all",   6'b111111, 1'b0, 0, 0, 0, 0, 0, -1);
    run_case("hold3",       6'b000100, 1'b0, 0, 0, 0, 2, 3, -1);
    run_case("mask_zero",   6'b000000, 1'b0, 0, 0, 0, 0, 0, -1);

    for (int r = 0; r < 6; r++) begin
      m = 6'($urandom_range(1, 63));
      do fg = int'($urandom_range(0, 5)); while (!m[fg]);
      run_case("random", m, 1'($urandom_range(0, 1)), fg, int'($urandom_range(0, 3)),
               15, 0, 0, -1);
    end

    // Asynchronous reset in the middle of the gap after gate 0.
    cur_case = "async_reset";
    fault_en = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 6'b000011);
    @(posedge clk); #2;
    applyStimulus(1'b0, 1'b0, 1'b0, 6'b000011);
    repeat (16) @(posedge clk);
    #6;
    checkOutput("gap_state", cyc, 32'({busy, blueled, done, redled}), 32'b1100);
    rst_n = 1'b0;
    #1;
    checkOutput("async_clear", cyc,
                32'({gate_sel, gate_a, gate_b, busy, done, err, redled, greenled, blueled}), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #2;

    run_case("after_reset", 6'b100010, 1'b0, 0, 0, 0, 0, 0, -1);

    repeat (3) @(posedge clk);
    #2;
    checkOutput("queue_drain", cyc, 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
